// File: rtl/spi_temp_pkg.sv
// Shared types and helpers for the multi-channel SPI temperature poller.
package spi_temp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    GAP
  } state_t;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_SCK_DIV    = 2;
  localparam int DEF_GAP_CYC    = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the channel index.
  function automatic int ch_w(input int n);
    return min1_clog2(n);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer for the SPI clock: ticks on the last clk of every
// SCK_DIV-long FSM phase and registers the SCK level chosen by the FSM.
module spi_sck_gen import spi_temp_pkg::*; #(
  parameter int SCK_DIV = DEF_SCK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sck_d,
  output logic tick,
  output logic sck
);

  localparam int DIV_W = min1_clog2(SCK_DIV);

  logic [DIV_W-1:0] div_cnt;

  assign tick = run && (div_cnt == DIV_W'(SCK_DIV - 1));

  // Phase counter restarts on every tick so each timed state gets SCK_DIV clks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // SCK follows the FSM's next-state decision so it changes with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck <= 1'b0;
    end else begin
      sck <= sck_d;
    end
  end

endmodule

// File: rtl/spi_temp_poller.sv
// Round-robin SPI master polling NUM_CH temperature sensors on a shared
// SCK/SIO bus, keeping the latest reading and a hysteretic alarm per channel.
module spi_temp_poller import spi_temp_pkg::*; #(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int SCK_DIV    = DEF_SCK_DIV,
  parameter int GAP_CYC    = DEF_GAP_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sio_in,
  input  logic [DATA_BITS-1:0]          thr_hi,
  input  logic [DATA_BITS-1:0]          thr_lo,
  output logic                          sck,
  output logic [NUM_CH-1:0]             cs_n,
  output logic [NUM_CH*DATA_BITS-1:0]   temp_out,
  output logic                          temp_valid,
  output logic [ch_w(NUM_CH)-1:0]       temp_ch,
  output logic [NUM_CH-1:0]             alarm,
  output logic                          busy
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int GAP_W = min1_clog2(GAP_CYC);

  state_t                state_q, state_d;
  logic                  tick, run, sck_d, enter_hi, start, frame_done, gap_last;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_BITS-1:0]  reading;

  // Set above thr_hi, clear below thr_lo, otherwise hold; set wins on overlap.
  function automatic logic alarm_next(input logic cur,
                                      input logic [DATA_BITS-1:0] val,
                                      input logic [DATA_BITS-1:0] hi,
                                      input logic [DATA_BITS-1:0] lo);
    if (val > hi) return 1'b1;
    if (val < lo) return 1'b0;
    return cur;
  endfunction

  assign run        = (state_q == SETUP) || (state_q == SCK_HI) ||
                      (state_q == SCK_LO) || (state_q == HOLD);
  assign start      = (state_q == IDLE) && enable;
  assign frame_done = (state_q == HOLD) && tick;
  assign gap_last   = (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign reading    = shift[FRAME_BITS-1 -: DATA_BITS];

  spi_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .sck_d (sck_d),
    .tick  (tick),
    .sck   (sck)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SCK is high exactly while in SCK_HI, and bits are
  // captured on the edge that enters SCK_HI (the rising SCK edge).
  always_comb begin
    state_d  = state_q;
    sck_d    = 1'b0;
    enter_hi = 1'b0;
    case (state_q)
      IDLE:    if (enable) state_d = SETUP;
      SETUP:   if (tick) state_d = SCK_HI;
      SCK_HI:  if (tick) state_d = SCK_LO;
      SCK_LO:  if (tick) state_d = (bit_cnt == BIT_W'(FRAME_BITS)) ? HOLD : SCK_HI;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sck_d    = (state_d == SCK_HI);
    enter_hi = sck_d && (state_q != SCK_HI);
  end

  // Chip select, busy, bit capture and channel sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n    <= '1;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
      gap_cnt <= '0;
      temp_ch <= '0;
    end else begin
      if (start) begin
        cs_n    <= ~(NUM_CH'(1) << temp_ch);
        busy    <= 1'b1;
        bit_cnt <= '0;
        shift   <= '0;
      end
      if (enter_hi) begin
        shift   <= (shift << 1) | FRAME_BITS'(sio_in);
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (frame_done) begin
        cs_n <= '1;
        busy <= 1'b0;
      end
      if (state_q == GAP) begin
        gap_cnt <= gap_last ? '0 : gap_cnt + GAP_W'(1);
        if (gap_last) begin
          temp_ch <= (temp_ch == CH_W'(NUM_CH - 1)) ? '0 : temp_ch + CH_W'(1);
        end
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // Reading write-back, valid pulse and alarm update for the finished channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_out   <= '0;
      temp_valid <= 1'b0;
      alarm      <= '0;
    end else begin
      temp_valid <= frame_done;
      for (int k = 0; k < NUM_CH; k++) begin
        if (frame_done && (temp_ch == CH_W'(k))) begin
          temp_out[k*DATA_BITS +: DATA_BITS] <= reading;
          alarm[k] <= alarm_next(alarm[k], reading, thr_hi, thr_lo);
        end
      end
    end
  end

endmodule
